// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multicycle
// controller (states, opcodes, control codes).
package mc_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ORI = 6'h0d;
  localparam logic [5:0] OP_LUI = 6'h0f;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2a;

  localparam logic [3:0] ALU_ADDU = 4'd0;
  localparam logic [3:0] ALU_SUBU = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_SLT  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_LUI  = 4'd6;

  localparam logic [2:0] NPC_SEQ = 3'd0;
  localparam logic [2:0] NPC_BEQ = 3'd1;
  localparam logic [2:0] NPC_J   = 3'd2;
  localparam logic [2:0] NPC_JR  = 3'd3;

  localparam logic [1:0] EXT_ZERO  = 2'd0;
  localparam logic [1:0] EXT_SIGN  = 2'd1;
  localparam logic [1:0] EXT_UPPER = 2'd2;

  localparam logic [1:0] MTR_ALU  = 2'd0;
  localparam logic [1:0] MTR_DM   = 2'd1;
  localparam logic [1:0] MTR_LINK = 2'd2;

  localparam logic [2:0] MW_NONE = 3'd0;
  localparam logic [2:0] MW_WORD = 3'd1;

  typedef struct packed {
    logic       PCWr;
    logic       IRWr;
    logic       RegWr;
    logic       RegDst;
    logic [1:0] ExtOp;
    logic       ALUSrc;
    logic [3:0] ALUctr;
    logic [2:0] nPC_sel;
    logic       MemReq;
    logic [2:0] MemWr;
    logic [1:0] MemtoReg;
  } ctrl_t;

  function automatic logic [3:0] alu_of(
    input logic [5:0] fn
  );
    logic [3:0] a;
    case (fn)
      FN_SUBU: a = ALU_SUBU;
      FN_AND:  a = ALU_AND;
      FN_OR:   a = ALU_OR;
      FN_SLT:  a = ALU_SLT;
      FN_SLL:  a = ALU_SLL;
      default: a = ALU_ADDU;
    endcase
    return a;
  endfunction

  function automatic logic is_known(
    input logic [5:0] op,
    input logic [5:0] fn
  );
    logic k;
    case (op)
      OP_R: begin
        case (fn)
          FN_ADDU, FN_SUBU, FN_AND,
          FN_OR, FN_SLT, FN_SLL,
          FN_JR:   k = 1'b1;
          default: k = 1'b0;
        endcase
      end
      OP_ORI, OP_LUI, OP_LW, OP_SW,
      OP_BEQ, OP_J, OP_JAL: k = 1'b1;
      default:              k = 1'b0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/mc_if.sv
// mc_if: control bundle between the multicycle
// controller (master) and the datapath (slave).
interface mc_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             MemReady;
  logic             PCWr;
  logic             IRWr;
  logic             RegWr;
  logic             RegDst;
  logic [1:0]       ExtOp;
  logic             ALUSrc;
  logic [3:0]       ALUctr;
  logic [2:0]       nPC_sel;
  logic             MemReq;
  logic [2:0]       MemWr;
  logic [1:0]       MemtoReg;
  logic [1:0]       DMcut_sel;
  logic             Halted;
  logic [CNT_W-1:0] InstrCnt;
  logic [2:0]       State;

  modport master (
    input  opcode, funct, MemReady,
    output PCWr, IRWr, RegWr, RegDst,
    output ExtOp, ALUSrc, ALUctr,
    output nPC_sel, MemReq, MemWr,
    output MemtoReg, DMcut_sel,
    output Halted, InstrCnt, State
  );

  modport slave (
    output opcode, funct, MemReady,
    input  PCWr, IRWr, RegWr, RegDst,
    input  ExtOp, ALUSrc, ALUctr,
    input  nPC_sel, MemReq, MemWr,
    input  MemtoReg, DMcut_sel,
    input  Halted, InstrCnt, State
  );
endinterface

// File: rtl/mc_decode.sv
// mc_decode: combinational map from state and
// latched op/funct to the datapath control vector.
module mc_decode
  import mc_pkg::*;
(
  input  state_e     i_state,
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  input  logic       i_mem_ready,
  output ctrl_t      o_ctrl
);

  logic w_r_alu;
  logic w_jr;
  logic w_mem;
  logic w_busy;
  ctrl_t w_c;

  assign w_jr    = (i_op == OP_R) && (i_funct == FN_JR);
  assign w_r_alu = (i_op == OP_R) && !w_jr;
  assign w_mem   = (i_op == OP_LW) || (i_op == OP_SW);
  assign w_busy  = (i_state == S_EX) ||
                   (i_state == S_MEM) ||
                   (i_state == S_WB);

  // ALU operand setup is held from EX through WB
  // so the result and address stay stable.
  always_comb begin
    w_c = '0;
    if (w_busy) begin
      unique case (1'b1)
        w_r_alu: w_c.ALUctr = alu_of(i_funct);
        (i_op == OP_ORI): begin
          w_c.ALUSrc = 1'b1;
          w_c.ExtOp  = EXT_ZERO;
          w_c.ALUctr = ALU_OR;
        end
        (i_op == OP_LUI): begin
          w_c.ALUSrc = 1'b1;
          w_c.ExtOp  = EXT_UPPER;
          w_c.ALUctr = ALU_LUI;
        end
        w_mem: begin
          w_c.ALUSrc = 1'b1;
          w_c.ExtOp  = EXT_SIGN;
          w_c.ALUctr = ALU_ADDU;
        end
        default: ;
      endcase
    end
    unique case (i_state)
      S_IF: w_c.IRWr = 1'b1;
      S_EX: begin
        unique case (1'b1)
          (i_op == OP_BEQ): begin
            w_c.ALUctr  = ALU_SUBU;
            w_c.nPC_sel = NPC_BEQ;
            w_c.PCWr    = 1'b1;
          end
          (i_op == OP_J): begin
            w_c.nPC_sel = NPC_J;
            w_c.PCWr    = 1'b1;
          end
          (i_op == OP_JAL): begin
            w_c.nPC_sel  = NPC_J;
            w_c.MemtoReg = MTR_LINK;
            w_c.RegWr    = 1'b1;
            w_c.PCWr     = 1'b1;
          end
          w_jr: begin
            w_c.nPC_sel = NPC_JR;
            w_c.PCWr    = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        w_c.MemReq = 1'b1;
        if (i_op == OP_SW) begin
          w_c.MemWr = MW_WORD;
          w_c.PCWr  = i_mem_ready;
        end
      end
      S_WB: begin
        w_c.RegWr  = 1'b1;
        w_c.PCWr   = 1'b1;
        w_c.RegDst = (i_op == OP_R);
        w_c.MemtoReg = (i_op == OP_LW) ?
                       MTR_DM : MTR_ALU;
      end
      default: ;
    endcase
  end

  assign o_ctrl = w_c;

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle sequencer holding state,
// op/funct latches, retire counter and halt flag.
module mc_controller
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic Clk,
  input  logic Reset,
  mc_if.master bus
);

  state_e           r_state;
  state_e           w_next;
  logic [5:0]       r_op;
  logic [5:0]       r_funct;
  logic [CNT_W-1:0] r_cnt;
  logic             r_halted;
  ctrl_t            w_ctrl;
  logic             w_to_mem;
  logic             w_to_if;

  localparam logic [CNT_W-1:0] ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  mc_decode u_dec (
    .i_state     (r_state),
    .i_op        (r_op),
    .i_funct     (r_funct),
    .i_mem_ready (bus.MemReady),
    .o_ctrl      (w_ctrl)
  );

  assign w_to_mem = (r_op == OP_LW) ||
                    (r_op == OP_SW);
  assign w_to_if  = (r_op == OP_BEQ) ||
                    (r_op == OP_J) ||
                    (r_op == OP_JAL) ||
                    ((r_op == OP_R) &&
                     (r_funct == FN_JR));

  // State register; reset wins over any transition.
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_IF;
    else       r_state <= w_next;
  end

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IF: w_next = S_ID;
      S_ID: w_next = is_known(bus.opcode, bus.funct)
                     ? S_EX : S_HALT;
      S_EX: begin
        if (w_to_mem)     w_next = S_MEM;
        else if (w_to_if) w_next = S_IF;
        else              w_next = S_WB;
      end
      S_MEM: begin
        if (bus.MemReady)
          w_next = (r_op == OP_SW) ? S_IF : S_WB;
      end
      S_WB:   w_next = S_IF;
      S_HALT: w_next = S_HALT;
      default: w_next = S_IF;
    endcase
  end

  // Instruction latch, retire counter, sticky halt.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_op     <= '0;
      r_funct  <= '0;
      r_cnt    <= '0;
      r_halted <= 1'b0;
    end else begin
      if (r_state == S_ID) begin
        r_op    <= bus.opcode;
        r_funct <= bus.funct;
      end
      if (w_ctrl.PCWr) r_cnt <= r_cnt + ONE;
      if (w_next == S_HALT) r_halted <= 1'b1;
    end
  end

  assign bus.PCWr      = w_ctrl.PCWr;
  assign bus.IRWr      = w_ctrl.IRWr;
  assign bus.RegWr     = w_ctrl.RegWr;
  assign bus.RegDst    = w_ctrl.RegDst;
  assign bus.ExtOp     = w_ctrl.ExtOp;
  assign bus.ALUSrc    = w_ctrl.ALUSrc;
  assign bus.ALUctr    = w_ctrl.ALUctr;
  assign bus.nPC_sel   = w_ctrl.nPC_sel;
  assign bus.MemReq    = w_ctrl.MemReq;
  assign bus.MemWr     = w_ctrl.MemWr;
  assign bus.MemtoReg  = w_ctrl.MemtoReg;
  assign bus.DMcut_sel = 2'b00;
  assign bus.Halted    = r_halted;
  assign bus.InstrCnt  = r_cnt;
  assign bus.State     = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: per-cycle scoreboard of expected
// control vectors for the multicycle controller.
module tb_mc_controller;

  logic Clk = 1'b0;
  logic Reset;

  mc_if #(.CNT_W(32)) bus ();

  mc_controller #(.CNT_W(32)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [2:0]  st;
    logic        pcwr;
    logic        irwr;
    logic        regwr;
    logic        regdst;
    logic [1:0]  ext;
    logic        alusrc;
    logic [3:0]  alu;
    logic [2:0]  npc;
    logic        memreq;
    logic [2:0]  memwr;
    logic [1:0]  mtr;
    logic [1:0]  dmcut;
    logic        halted;
    logic [31:0] cnt;
  } out_t;

  typedef struct packed {
    logic mr;
    out_t o;
  } rec_t;

  rec_t   sb[$];
  int     total = 0;
  int     bad = 0;
  logic [31:0] m_cnt = 0;

  function automatic out_t sample();
    out_t o;
    o.st     = bus.State;
    o.pcwr   = bus.PCWr;
    o.irwr   = bus.IRWr;
    o.regwr  = bus.RegWr;
    o.regdst = bus.RegDst;
    o.ext    = bus.ExtOp;
    o.alusrc = bus.ALUSrc;
    o.alu    = bus.ALUctr;
    o.npc    = bus.nPC_sel;
    o.memreq = bus.MemReq;
    o.memwr  = bus.MemWr;
    o.mtr    = bus.MemtoReg;
    o.dmcut  = bus.DMcut_sel;
    o.halted = bus.Halted;
    o.cnt    = bus.InstrCnt;
    return o;
  endfunction

  task automatic push(
    input logic       mr,
    input logic [2:0] st,
    input logic       pc, ir, rw, rd,
    input logic [1:0] ext,
    input logic       as,
    input logic [3:0] alu,
    input logic [2:0] np,
    input logic       mq,
    input logic [2:0] mw,
    input logic [1:0] mt
  );
    rec_t r;
    r.mr       = mr;
    r.o.st     = st;
    r.o.pcwr   = pc;
    r.o.irwr   = ir;
    r.o.regwr  = rw;
    r.o.regdst = rd;
    r.o.ext    = ext;
    r.o.alusrc = as;
    r.o.alu    = alu;
    r.o.npc    = np;
    r.o.memreq = mq;
    r.o.memwr  = mw;
    r.o.mtr    = mt;
    r.o.dmcut  = 2'b00;
    r.o.halted = (st == 3'd5);
    r.o.cnt    = m_cnt;
    sb.push_back(r);
    if (pc) m_cnt = m_cnt + 1;
  endtask

  task automatic push_if(input logic mr);
    push(mr, 3'd0, 0, 1, 0, 0, 2'd0, 0,
         4'd0, 3'd0, 0, 3'd0, 2'd0);
  endtask

  task automatic push_id(input logic mr);
    push(mr, 3'd1, 0, 0, 0, 0, 2'd0, 0,
         4'd0, 3'd0, 0, 3'd0, 2'd0);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    bus.opcode = 6'h00;
    bus.funct = 6'h21;
    bus.MemReady = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    total++;
    if (bus.State !== 3'd0) begin
      bad++;
      $display("FAIL reset_state got %0d want 0",
               bus.State);
    end
    total++;
    if (bus.IRWr !== 1'b1) begin
      bad++;
      $display("FAIL reset_irwr got %b want 1",
               bus.IRWr);
    end
    total++;
    if (bus.InstrCnt !== 32'd0) begin
      bad++;
      $display("FAIL reset_cnt got %0d want 0",
               bus.InstrCnt);
    end
    total++;
    if (bus.Halted !== 1'b0) begin
      bad++;
      $display("FAIL reset_halt got %b want 0",
               bus.Halted);
    end
    m_cnt = 0;
  endtask

  task automatic test_addu();
    rec_t e;
    out_t g;
    int   c = 0;
    bus.opcode = 6'h00;
    bus.funct = 6'h21;
    push_if(0);
    push_id(0);
    push(0, 3'd2, 0, 0, 0, 0, 2'd0, 0,
         4'd0, 3'd0, 0, 3'd0, 2'd0);
    push(0, 3'd4, 1, 0, 1, 1, 2'd0, 0,
         4'd0, 3'd0, 0, 3'd0, 2'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge Clk);
      bus.MemReady = e.mr;
      #1 g = sample();
      total++;
      if (g !== e.o) begin
        bad++;
        $display("FAIL addu c%0d got %h want %h",
                 c, g, e.o);
      end
      c++;
    end
  endtask

  task automatic test_alu();
    rec_t e;
    out_t g;
    logic [5:0] op [7];
    logic [5:0] fn [7];
    logic [3:0] al [7];
    logic       as [7];
    logic [1:0] ex [7];
    logic       rd [7];
    op = '{6'h00, 6'h00, 6'h00, 6'h00,
           6'h00, 6'h0d, 6'h0f};
    fn = '{6'h23, 6'h24, 6'h25, 6'h2a,
           6'h00, 6'h21, 6'h21};
    al = '{4'd1, 4'd2, 4'd3, 4'd4,
           4'd5, 4'd3, 4'd6};
    as = '{0, 0, 0, 0, 0, 1, 1};
    ex = '{2'd0, 2'd0, 2'd0, 2'd0,
           2'd0, 2'd0, 2'd2};
    rd = '{1, 1, 1, 1, 1, 0, 0};
    for (int i = 0; i < 7; i++) begin
      bus.opcode = op[i];
      bus.funct = fn[i];
      push_if(0);
      push_id(0);
      push(0, 3'd2, 0, 0, 0, 0, ex[i], as[i],
           al[i], 3'd0, 0, 3'd0, 2'd0);
      push(0, 3'd4, 1, 0, 1, rd[i], ex[i], as[i],
           al[i], 3'd0, 0, 3'd0, 2'd0);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        @(negedge Clk);
        bus.MemReady = e.mr;
        #1 g = sample();
        total++;
        if (g !== e.o) begin
          bad++;
          $display("FAIL alu%0d got %h want %h",
                   i, g, e.o);
        end
      end
    end
  endtask

  task automatic test_lw_wait();
    rec_t e;
    out_t g;
    int   c = 0;
    bus.opcode = 6'h23;
    bus.funct = 6'h3f;
    push_if(0);
    push_id(0);
    push(0, 3'd2, 0, 0, 0, 0, 2'd1, 1,
         4'd0, 3'd0, 0, 3'd0, 2'd0);
    for (int i = 0; i < 4; i++)
      push(i == 3, 3'd3, 0, 0, 0, 0, 2'd1, 1,
           4'd0, 3'd0, 1, 3'd0, 2'd0);
    push(0, 3'd4, 1, 0, 1, 0, 2'd1, 1,
         4'd0, 3'd0, 0, 3'd0, 2'd1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge Clk);
      bus.MemReady = e.mr;
      #1 g = sample();
      total++;
      if (g !== e.o) begin
        bad++;
        $display("FAIL lw c%0d got %h want %h",
                 c, g, e.o);
      end
      c++;
    end
  endtask

  task automatic test_sw_now();
    rec_t e;
    out_t g;
    int   c = 0;
    bus.opcode = 6'h2b;
    bus.funct = 6'h00;
    push_if(0);
    push_id(0);
    push(0, 3'd2, 0, 0, 0, 0, 2'd1, 1,
         4'd0, 3'd0, 0, 3'd0, 2'd0);
    push(1, 3'd3, 1, 0, 0, 0, 2'd1, 1,
         4'd0, 3'd0, 1, 3'd1, 2'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge Clk);
      bus.MemReady = e.mr;
      #1 g = sample();
      total++;
      if (g !== e.o) begin
        bad++;
        $display("FAIL sw c%0d got %h want %h",
                 c, g, e.o);
      end
      c++;
    end
  endtask

  task automatic test_branch();
    rec_t e;
    out_t g;
    logic [5:0] op [4];
    logic [5:0] fn [4];
    logic [3:0] al [4];
    logic [2:0] np [4];
    logic       rw [4];
    logic [1:0] mt [4];
    op = '{6'h04, 6'h03, 6'h00, 6'h02};
    fn = '{6'h21, 6'h21, 6'h08, 6'h00};
    al = '{4'd1, 4'd0, 4'd0, 4'd0};
    np = '{3'd1, 3'd2, 3'd3, 3'd2};
    rw = '{0, 1, 0, 0};
    mt = '{2'd0, 2'd2, 2'd0, 2'd0};
    for (int i = 0; i < 4; i++) begin
      bus.opcode = op[i];
      bus.funct = fn[i];
      push_if(1);
      push_id(1);
      push(1, 3'd2, 1, 0, rw[i], 0, 2'd0, 0,
           al[i], np[i], 0, 3'd0, mt[i]);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        @(negedge Clk);
        bus.MemReady = e.mr;
        #1 g = sample();
        total++;
        if (g !== e.o) begin
          bad++;
          $display("FAIL br%0d got %h want %h",
                   i, g, e.o);
        end
      end
    end
  endtask

  task automatic test_mem_reset();
    rec_t e;
    out_t g;
    bus.opcode = 6'h2b;
    bus.funct = 6'h00;
    push_if(0);
    push_id(0);
    push(0, 3'd2, 0, 0, 0, 0, 2'd1, 1,
         4'd0, 3'd0, 0, 3'd0, 2'd0);
    push(0, 3'd3, 0, 0, 0, 0, 2'd1, 1,
         4'd0, 3'd0, 1, 3'd1, 2'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge Clk);
      bus.MemReady = e.mr;
      #1 g = sample();
      total++;
      if (g !== e.o) begin
        bad++;
        $display("FAIL memrst got %h want %h",
                 g, e.o);
      end
    end
    Reset = 1'b1;
    @(posedge Clk);
    #1 Reset = 1'b0;
    m_cnt = 0;
    total++;
    if ({bus.MemReq, bus.MemWr, bus.PCWr} !==
        5'b0) begin
      bad++;
      $display("FAIL memrst_req got %b%b%b want 0",
               bus.MemReq, bus.MemWr, bus.PCWr);
    end
    total++;
    if (bus.State !== 3'd0 ||
        bus.InstrCnt !== 32'd0) begin
      bad++;
      $display("FAIL memrst_st got %0d/%0d want 0/0",
               bus.State, bus.InstrCnt);
    end
  endtask

  task automatic test_halt();
    rec_t e;
    out_t g;
    logic [5:0] op [2];
    logic [5:0] fn [2];
    op = '{6'h3f, 6'h00};
    fn = '{6'h21, 6'h3f};
    for (int i = 0; i < 2; i++) begin
      bus.opcode = op[i];
      bus.funct = fn[i];
      push_if(0);
      push_id(0);
      for (int k = 0; k < 10; k++)
        push(k[0], 3'd5, 0, 0, 0, 0, 2'd0, 0,
             4'd0, 3'd0, 0, 3'd0, 2'd0);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        @(negedge Clk);
        bus.MemReady = e.mr;
        #1 g = sample();
        total++;
        if (g !== e.o) begin
          bad++;
          $display("FAIL halt%0d got %h want %h",
                   i, g, e.o);
        end
      end
      Reset = 1'b1;
      @(posedge Clk);
      #1 Reset = 1'b0;
      m_cnt = 0;
      total++;
      if (bus.State !== 3'd0 ||
          bus.Halted !== 1'b0 ||
          bus.IRWr !== 1'b1) begin
        bad++;
        $display("FAIL unhalt%0d got %0d/%b/%b want 0/0/1",
                 i, bus.State, bus.Halted, bus.IRWr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_alu();
    test_lw_wait();
    test_sw_now();
    test_branch();
    test_mem_reset();
    test_addu();
    test_halt();
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
